// File: rtl/cpu_seq_pkg.sv
// Shared types and instruction-field constants for the fetch/execute sequencer.
package cpu_seq_pkg;

    localparam int unsigned INSTR_W = 16;

    // Sequencer states; strobes are decoded one-hot from these.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC1 = 2'd2,
        ST_EXEC2 = 2'd3
    } seq_state_e;

    // Instruction register field positions.
    localparam int unsigned CODE_HI = 15;
    localparam int unsigned CODE_LO = 14;
    localparam int unsigned CIN_HI  = 13;
    localparam int unsigned CIN_LO  = 12;
    localparam int unsigned COND_HI = 11;
    localparam int unsigned COND_LO = 8;
    localparam int unsigned CW_BIT  = 7;
    localparam int unsigned OP_HI   = 6;
    localparam int unsigned OP_LO   = 4;

    localparam logic [1:0] CODE_ARM = 2'b11;

    // ARM-class instructions complete in EXEC1 and skip EXEC2.
    function automatic logic is_arm(input logic [INSTR_W-1:0] instr);
        return instr[CODE_HI:CODE_LO] == CODE_ARM;
    endfunction

endpackage

// File: rtl/status_flags.sv
// CARRY and SKIP status flops.
// Ports: clk/reset (sync, active-high); carry_i/carry_en_i load CARRY;
//        skip_i/skip_en_i load SKIP; skip_clr_i clears SKIP once the
//        skipped word has been consumed; carry_o/skip_o are the flop outputs.
module status_flags (
    input  logic clk,
    input  logic reset,
    input  logic carry_i,
    input  logic carry_en_i,
    input  logic skip_i,
    input  logic skip_en_i,
    input  logic skip_clr_i,
    output logic carry_o,
    output logic skip_o
);

    logic carry_q, carry_d;
    logic skip_q,  skip_d;

    // Enable-load; an explicit load wins over clear (never both in one state).
    always_comb begin
        carry_d = carry_q;
        skip_d  = skip_q;
        if (carry_en_i) carry_d = carry_i;
        if (skip_en_i)       skip_d = skip_i;
        else if (skip_clr_i) skip_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            skip_q  <= skip_d;
        end
    end

    assign carry_o = carry_q;
    assign skip_o  = skip_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute controller for the 16-bit CPU: owns PC, IR, the status
// flags and the one-hot fetch/exec1/exec2 timing strobes.
// Ports: clk, reset (sync, active-high), run; memdata/memaddr program memory;
//        ir; fetch/exec1/exec2/halted strobes; alu_carry/alu_carryen,
//        alu_skip/alu_skipen flag updates; pc_load/pc_target jumps;
//        carrystatus/skipstatus flag outputs.
module instr_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] memdata,
    output logic [ADDR_W-1:0]  memaddr,
    output logic [INSTR_W-1:0] ir,
    output logic               fetch,
    output logic               exec1,
    output logic               exec2,
    output logic               halted,
    input  logic               alu_carry,
    input  logic               alu_carryen,
    input  logic               alu_skip,
    input  logic               alu_skipen,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               carrystatus,
    output logic               skipstatus
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               fetch_q, exec1_q, exec2_q, halted_q;
    logic               carry_en, skip_en, skip_clr;
    logic               skip_flag;

    // Next-state, PC/IR update and flag-enable decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_en = 1'b0;
        skip_en  = 1'b0;
        skip_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                pc_d = pc_q + ADDR_W'(1);
                if (skip_flag) begin
                    // Discard this word: IR holds, instruction never executes.
                    skip_clr = 1'b1;
                    state_d  = run ? ST_FETCH : ST_IDLE;
                end else begin
                    ir_d    = memdata;
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                carry_en = alu_carryen;
                skip_en  = alu_skipen;
                if (pc_load) pc_d = pc_target;
                if (is_arm(ir_q)) state_d = run ? ST_FETCH : ST_IDLE;
                else              state_d = ST_EXEC2;
            end
            ST_EXEC2: begin
                if (pc_load) pc_d = pc_target;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC, IR and strobes registered from the next state so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            fetch_q  <= 1'b0;
            exec1_q  <= 1'b0;
            exec2_q  <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            fetch_q  <= (state_d == ST_FETCH);
            exec1_q  <= (state_d == ST_EXEC1);
            exec2_q  <= (state_d == ST_EXEC2);
            halted_q <= (state_d == ST_IDLE);
        end
    end

    status_flags u_flags (
        .clk        (clk),
        .reset      (reset),
        .carry_i    (alu_carry),
        .carry_en_i (carry_en),
        .skip_i     (alu_skip),
        .skip_en_i  (skip_en),
        .skip_clr_i (skip_clr),
        .carry_o    (carrystatus),
        .skip_o     (skip_flag)
    );

    assign memaddr    = pc_q;
    assign ir         = ir_q;
    assign fetch      = fetch_q;
    assign exec1      = exec1_q;
    assign exec2      = exec2_q;
    assign halted     = halted_q;
    assign skipstatus = skip_flag;

endmodule
